// File: rtl/megaram_mapper_gen.sv
// Cartridge mapper for the 4000-BFFFh window: linear/Konami/SCC/ASCII modes,
// bank mirroring by mask and a req/ack memory handshake that stalls the Z80.
module megaram_mapper_gen #(
  parameter int ADDR_W = 21,
  parameter bit LIN_WR_EN = 1'b1,
  localparam int BANK_W = ADDR_W - 13
) (
  input  logic              clk_27m,
  input  logic              bus_reset_n,
  input  logic              slot_sel,
  input  logic [15:0]       bus_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              bus_rd_n,
  input  logic              bus_wr_n,
  input  logic [2:0]        map_mode,
  input  logic [BANK_W-1:0] bank_mask,
  output logic              mem_req,
  output logic              mem_wrt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        bus_dout,
  output logic              bus_den,
  output logic              bus_wait_n,
  output logic              scc_sel
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t state_q, state_d;
  logic rd_n_q, wr_n_q;
  logic mem_req_q, mem_req_d;
  logic mem_wrt_q, mem_wrt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_wdata_q, mem_wdata_d;
  logic [7:0] bus_dout_q, bus_dout_d;
  logic bus_den_q, bus_den_d;
  logic scc_sel_q, scc_sel_d;
  logic [BANK_W-1:0] bank_q [4];
  logic [BANK_W-1:0] bank_d [4];

  logic lin, idle, rel, in_win, scc_hit;
  logic rd_st, wr_st, rd_go, wr_go, go;
  logic kon_w, scc_w, a8_w, a16_w;
  logic [1:0] w;
  logic [BANK_W-1:0] raw, bank, v, v2;
  logic [ADDR_W-1:0] map_addr, lin_addr;

  always_comb begin
    lin = (map_mode == 3'd0) || (map_mode > 3'd4);
    idle = (state_q == IDLE);
    rel = bus_rd_n & bus_wr_n;
    rd_st = slot_sel & rd_n_q & ~bus_rd_n;
    wr_st = slot_sel & wr_n_q & ~bus_wr_n;
    in_win = bus_addr[15] ^ bus_addr[14];
    w = {~bus_addr[14], bus_addr[13]};
    raw = bank_q[w];
    if (map_mode == 3'd1 && w == 2'd0) raw = '0;
    bank = raw & bank_mask;
    map_addr = {bank, bus_addr[12:0]};
    lin_addr = ADDR_W'(bus_addr);
    scc_hit = (map_mode == 3'd2) && (bus_addr[15:8] == 8'h98)
              && (bank_q[2][5:0] == 6'h3F);
    rd_go = rd_st & (lin | (in_win & ~scc_hit));
    wr_go = wr_st & lin & LIN_WR_EN;
    go = idle & (rd_go | wr_go);
  end

  // Bank register decode; only writes in a mapper mode while idle.
  always_comb begin
    v = BANK_W'(cpu_dout);
    v2 = {v[BANK_W-2:0], 1'b0};
    kon_w = (map_mode == 3'd1) && (bus_addr[15:13] inside {3'b011, 3'b100, 3'b101});
    scc_w = (map_mode == 3'd2) && in_win && (bus_addr[12:11] == 2'b10);
    a8_w = (map_mode == 3'd3) && (bus_addr[15:13] == 3'b011);
    a16_w = (map_mode == 3'd4) && (bus_addr[15:13] == 3'b011) && !bus_addr[11];
    for (int i = 0; i < 4; i++) bank_d[i] = bank_q[i];
    if (idle && wr_st && !lin) begin
      unique case (1'b1)
        kon_w: bank_d[w] = v;
        scc_w: bank_d[{bus_addr[15], bus_addr[13]}] = v;
        a8_w: bank_d[bus_addr[12:11]] = v;
        a16_w: begin
          bank_d[{bus_addr[12], 1'b0}] = v2;
          bank_d[{bus_addr[12], 1'b1}] = v2 | BANK_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_wrt_d = mem_wrt_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    bus_dout_d = bus_dout_q;
    bus_den_d = bus_den_q;
    scc_sel_d = scc_sel_q;
    if (rel) scc_sel_d = 1'b0;
    else if (idle && (rd_st || wr_st) && scc_hit) scc_sel_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REQ;
          mem_req_d = 1'b1;
          mem_wrt_d = wr_st;
          mem_addr_d = lin ? lin_addr : map_addr;
          mem_wdata_d = cpu_dout;
        end
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_wrt_d = 1'b0;
          if (rel) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            if (!mem_wrt_q) begin
              bus_dout_d = mem_rdata;
              bus_den_d = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (rel) begin
          state_d = IDLE;
          bus_den_d = 1'b0;
          bus_dout_d = 8'hFF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_27m or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state_q <= IDLE;
      rd_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      mem_req_q <= 1'b0;
      mem_wrt_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      bus_dout_q <= 8'hFF;
      bus_den_q <= 1'b0;
      scc_sel_q <= 1'b0;
      bank_q[0] <= BANK_W'(0);
      bank_q[1] <= BANK_W'(1);
      bank_q[2] <= BANK_W'(2);
      bank_q[3] <= BANK_W'(3);
    end else begin
      state_q <= state_d;
      rd_n_q <= bus_rd_n;
      wr_n_q <= bus_wr_n;
      mem_req_q <= mem_req_d;
      mem_wrt_q <= mem_wrt_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      bus_dout_q <= bus_dout_d;
      bus_den_q <= bus_den_d;
      scc_sel_q <= scc_sel_d;
      for (int i = 0; i < 4; i++) bank_q[i] <= bank_d[i];
    end
  end

  // Wait drops combinationally in the strobe cycle so the Z80 stalls at once.
  assign bus_wait_n = ~(go | (state_q == REQ));
  assign mem_req = mem_req_q;
  assign mem_wrt = mem_wrt_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_dout = bus_dout_q;
  assign bus_den = bus_den_q;
  assign scc_sel = scc_sel_q;

endmodule

// File: tb/tb_megaram_mapper_gen.sv
// Directed bench for megaram_mapper_gen: bank decode, mask,
// SCC select, wait timing and reset behaviour.
module tb_megaram_mapper_gen;

  logic clk_27m = 1'b0;
  logic bus_reset_n;
  logic slot_sel;
  logic [15:0] bus_addr;
  logic [7:0] cpu_dout;
  logic bus_rd_n, bus_wr_n;
  logic [2:0] map_mode;
  logic [7:0] bank_mask;
  logic mem_req, mem_wrt;
  logic [20:0] mem_addr;
  logic [7:0] mem_wdata;
  logic mem_ack;
  logic [7:0] mem_rdata;
  logic [7:0] bus_dout;
  logic bus_den, bus_wait_n, scc_sel;

  int total = 0;
  int bad = 0;

  always #5 clk_27m = ~clk_27m;

  megaram_mapper_gen dut (
    .clk_27m(clk_27m), .bus_reset_n(bus_reset_n), .slot_sel(slot_sel),
    .bus_addr(bus_addr), .cpu_dout(cpu_dout), .bus_rd_n(bus_rd_n),
    .bus_wr_n(bus_wr_n), .map_mode(map_mode), .bank_mask(bank_mask),
    .mem_req(mem_req), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_dout(bus_dout), .bus_den(bus_den), .bus_wait_n(bus_wait_n),
    .scc_sel(scc_sel)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic acc(input string tag, input logic wr,
                     input logic [15:0] a, input logic [7:0] wd,
                     input int dly, input logic [7:0] rd,
                     input logic [20:0] ea);
    int lowc;
    lowc = 0;
    @(negedge clk_27m);
    bus_addr = a;
    cpu_dout = wd;
    if (wr) bus_wr_n = 1'b0;
    else bus_rd_n = 1'b0;
    #1 if (!bus_wait_n) lowc++;
    @(negedge clk_27m);
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".addr"}, 32'(mem_addr), 32'(ea));
    chk({tag, ".wrt"}, 32'(mem_wrt), 32'(wr));
    if (wr) chk({tag, ".wdata"}, 32'(mem_wdata), 32'(wd));
    for (int k = 1; k <= dly; k++) begin
      #1 if (!bus_wait_n) lowc++;
      if (k == dly) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk_27m);
    end
    mem_ack = 1'b0;
    #1;
    chk({tag, ".waitn"}, 32'(bus_wait_n), 32'd1);
    chk({tag, ".reqoff"}, 32'(mem_req), 32'd0);
    chk({tag, ".waitcyc"}, 32'(lowc), 32'(dly + 1));
    chk({tag, ".den"}, 32'(bus_den), wr ? 32'd0 : 32'd1);
    if (!wr) chk({tag, ".dout"}, 32'(bus_dout), 32'(rd));
    bus_rd_n = 1'b1;
    bus_wr_n = 1'b1;
    @(negedge clk_27m);
    chk({tag, ".denoff"}, 32'(bus_den), 32'd0);
    chk({tag, ".doutff"}, 32'(bus_dout), 32'hFF);
  endtask

  task automatic bank_wr(input string tag, input logic [15:0] a,
                         input logic [7:0] d);
    @(negedge clk_27m);
    bus_addr = a;
    cpu_dout = d;
    bus_wr_n = 1'b0;
    #1 chk({tag, ".waitn"}, 32'(bus_wait_n), 32'd1);
    @(negedge clk_27m);
    chk({tag, ".noreq"}, 32'(mem_req), 32'd0);
    bus_wr_n = 1'b1;
    @(negedge clk_27m);
  endtask

  task automatic noacc(input string tag, input logic [15:0] a,
                       input logic exp_scc);
    @(negedge clk_27m);
    bus_addr = a;
    bus_rd_n = 1'b0;
    #1 chk({tag, ".waitn"}, 32'(bus_wait_n), 32'd1);
    @(negedge clk_27m);
    chk({tag, ".noreq"}, 32'(mem_req), 32'd0);
    chk({tag, ".scc"}, 32'(scc_sel), 32'(exp_scc));
    chk({tag, ".den"}, 32'(bus_den), 32'd0);
    bus_rd_n = 1'b1;
    @(negedge clk_27m);
    chk({tag, ".sccoff"}, 32'(scc_sel), 32'd0);
  endtask

  initial begin
    bus_reset_n = 1'b0;
    slot_sel = 1'b1;
    bus_addr = 16'h0000;
    cpu_dout = 8'h00;
    bus_rd_n = 1'b1;
    bus_wr_n = 1'b1;
    map_mode = 3'd1;
    bank_mask = 8'hFF;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    repeat (2) @(negedge clk_27m);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.wrt", 32'(mem_wrt), 32'd0);
    chk("rst.waitn", 32'(bus_wait_n), 32'd1);
    chk("rst.den", 32'(bus_den), 32'd0);
    chk("rst.dout", 32'(bus_dout), 32'hFF);
    chk("rst.scc", 32'(scc_sel), 32'd0);
    bus_reset_n = 1'b1;
    @(negedge clk_27m);

    acc("kon8000", 1'b0, 16'h8000, 8'h00, 1, 8'h11, 21'h04000);
    noacc("konC000", 16'hC000, 1'b0);

    map_mode = 3'd3;
    bank_wr("a8w", 16'h7000, 8'h15);
    acc("a8rd", 1'b0, 16'h9234, 8'h00, 2, 8'h5A, 21'h2B234);

    map_mode = 3'd4;
    bank_mask = 8'h1F;
    bank_wr("a16w", 16'h6000, 8'h83);
    acc("a16r0", 1'b0, 16'h4000, 8'h00, 1, 8'h21, 21'h0C000);
    acc("a16r1", 1'b0, 16'h6000, 8'h00, 3, 8'h22, 21'h0E000);

    map_mode = 3'd2;
    bank_mask = 8'hFF;
    bank_wr("sccw", 16'h9000, 8'h3F);
    noacc("scc9810", 16'h9810, 1'b1);
    acc("scc9910", 1'b0, 16'h9910, 8'h00, 1, 8'h33, 21'h7F910);

    map_mode = 3'd0;
    acc("linwr", 1'b1, 16'hC000, 8'hAA, 5, 8'h00, 21'h0C000);

    @(negedge clk_27m);
    bus_addr = 16'h1234;
    bus_rd_n = 1'b0;
    @(negedge clk_27m);
    chk("rel.req", 32'(mem_req), 32'd1);
    chk("rel.addr", 32'(mem_addr), 32'h01234);
    bus_rd_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 8'h77;
    @(negedge clk_27m);
    mem_ack = 1'b0;
    chk("rel.reqoff", 32'(mem_req), 32'd0);
    chk("rel.den", 32'(bus_den), 32'd0);
    chk("rel.dout", 32'(bus_dout), 32'hFF);
    chk("rel.waitn", 32'(bus_wait_n), 32'd1);
    acc("linrd", 1'b0, 16'h2345, 8'h00, 1, 8'h44, 21'h02345);

    map_mode = 3'd3;
    bank_wr("a8w0", 16'h6000, 8'h09);
    acc("a8r4000", 1'b0, 16'h4000, 8'h00, 1, 8'h55, 21'h12000);
    map_mode = 3'd1;
    acc("konr0", 1'b0, 16'h4123, 8'h00, 1, 8'h56, 21'h00123);

    map_mode = 3'd3;
    @(negedge clk_27m);
    bus_addr = 16'h8000;
    bus_rd_n = 1'b0;
    @(negedge clk_27m);
    chk("mrst.req", 32'(mem_req), 32'd1);
    #2 bus_reset_n = 1'b0;
    #1 chk("mrst.reqoff", 32'(mem_req), 32'd0);
    bus_rd_n = 1'b1;
    @(negedge clk_27m);
    bus_reset_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    @(negedge clk_27m);
    mem_ack = 1'b0;
    chk("late.req", 32'(mem_req), 32'd0);
    chk("late.den", 32'(bus_den), 32'd0);
    chk("late.dout", 32'(bus_dout), 32'hFF);
    acc("rreg0", 1'b0, 16'h4000, 8'h00, 1, 8'h60, 21'h00000);
    acc("rreg3", 1'b0, 16'hA000, 8'h00, 1, 8'h61, 21'h06000);
    map_mode = 3'd1;
    acc("rkon8000", 1'b0, 16'h8000, 8'h00, 2, 8'h62, 21'h04000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
